// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - AHB-Lite bus master running SINGLE/INCR4 commands
module ahb_master #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [31:0]  cmd_addr,
  input  logic [2:0]   cmd_size,
  input  logic         cmd_incr4,
  input  logic         cmd_lock,
  input  logic [127:0] cmd_wdata,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  output logic         done,
  output logic         done_err,
  output logic [31:0]  HADDR,
  output logic         HWRITE,
  output logic [2:0]   HSIZE,
  output logic [2:0]   HBURST,
  output logic [3:0]   HPROT,
  output logic [1:0]   HTRANS,
  output logic         HMASTLOCK,
  output logic [31:0]  HWDATA,
  output logic [3:0]   HWSTRB,
  input  logic [31:0]  HRDATA,
  input  logic         HREADY,
  input  logic         HRESP
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_XFER, S_DRAIN, S_FIN} state_t;

  state_t r_state;
  state_t w_nstate;

  logic          r_rdy_en;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [2:0]    r_size;
  logic          r_incr4;
  logic          r_lock;
  logic [127:0]  r_wdata;
  logic          r_err;
  logic [1:0]    r_abeat;
  logic          r_addr_active;
  logic          r_data_active;
  logic [TW-1:0] r_tcnt;

  logic          w_accept;
  logic          w_illegal;
  logic [31:0]   w_last_addr;
  logic          w_last_abeat;
  logic          w_err_first;
  logic          w_err_final;
  logic          w_tmo;

  // Byte lanes touched by one transfer; reads never assert strobes
  function automatic logic [3:0] f_strb(input logic [2:0] sz, input logic [1:0] a, input logic wr);
    logic [3:0] s;
    s = 4'h0;
    if (wr) begin
      case (sz)
        3'd0:    s = 4'b0001 << a;
        3'd1:    s = 4'b0011 << {a[1], 1'b0};
        default: s = 4'hF;
      endcase
    end
    return s;
  endfunction

  assign HPROT     = 4'b0011;
  assign cmd_ready = r_rdy_en && (r_state == S_IDLE);
  assign done      = (r_state == S_FIN);
  assign done_err  = (r_state == S_FIN) && r_err;

  // Command legality and bus-response qualifiers
  always_comb begin
    w_accept     = cmd_valid && cmd_ready;
    w_last_addr  = r_addr + (32'd3 << r_size[1:0]);
    w_illegal    = (r_size > 3'd2)
                || ((r_size == 3'd1) && r_addr[0])
                || ((r_size == 3'd2) && (r_addr[1:0] != 2'b00))
                || (r_incr4 && (|((r_addr ^ w_last_addr) & 32'hFFFF_FC00)));
    w_last_abeat = !r_incr4 || (r_abeat == 2'd3);
    w_err_first  = r_data_active && !HREADY && HRESP;
    w_err_final  = r_data_active && HREADY && HRESP;
    w_tmo        = r_data_active && !HREADY && (r_tcnt == TMO_LAST);
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_nstate;
  end

  // Next-state decode
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nstate = S_CHECK;
      S_CHECK: w_nstate = w_illegal ? S_FIN : S_XFER;
      S_XFER, S_DRAIN: begin
        if (w_err_final || w_tmo)                           w_nstate = S_FIN;
        else if (w_err_first)                               w_nstate = S_DRAIN;
        else if (HREADY && r_addr_active && w_last_abeat)   w_nstate = S_DRAIN;
        else if (HREADY && !r_addr_active && r_data_active) w_nstate = S_FIN;
      end
      S_FIN:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Command latch, pipelined address/data phases, timeout and read return
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rdy_en      <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= 32'h0;
      r_size        <= 3'd0;
      r_incr4       <= 1'b0;
      r_lock        <= 1'b0;
      r_wdata       <= 128'h0;
      r_err         <= 1'b0;
      r_abeat       <= 2'd0;
      r_addr_active <= 1'b0;
      r_data_active <= 1'b0;
      r_tcnt        <= '0;
      HTRANS        <= TR_IDLE;
      HADDR         <= 32'h0;
      HWRITE        <= 1'b0;
      HSIZE         <= 3'd2;
      HBURST        <= 3'd0;
      HMASTLOCK     <= 1'b0;
      HWDATA        <= 32'h0;
      HWSTRB        <= 4'h0;
      rd_valid      <= 1'b0;
      rd_data       <= 32'h0;
    end else begin
      r_rdy_en <= 1'b1;
      rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_size  <= cmd_size;
            r_incr4 <= cmd_incr4;
            r_lock  <= cmd_lock;
            r_wdata <= cmd_wdata;
            r_err   <= 1'b0;
          end
        end
        S_CHECK: begin
          r_tcnt        <= '0;
          r_abeat       <= 2'd0;
          r_data_active <= 1'b0;
          if (w_illegal) begin
            r_err <= 1'b1;
          end else begin
            HTRANS        <= TR_NONSEQ;
            HADDR         <= r_addr;
            HWRITE        <= r_write;
            HSIZE         <= r_size;
            HBURST        <= r_incr4 ? 3'b011 : 3'b000;
            HMASTLOCK     <= r_lock;
            HWSTRB        <= f_strb(r_size, r_addr[1:0], r_write);
            r_addr_active <= 1'b1;
          end
        end
        S_XFER, S_DRAIN: begin
          if (r_data_active && !HREADY) r_tcnt <= r_tcnt + 1'b1;
          else                          r_tcnt <= '0;
          if (w_err_final || w_tmo) begin
            HTRANS        <= TR_IDLE;
            HMASTLOCK     <= 1'b0;
            r_addr_active <= 1'b0;
            r_data_active <= 1'b0;
            r_err         <= 1'b1;
          end else if (w_err_first) begin
            // Cancel the pending address phase while the slave finishes the error
            HTRANS        <= TR_IDLE;
            HMASTLOCK     <= 1'b0;
            r_addr_active <= 1'b0;
            r_err         <= 1'b1;
          end else if (HREADY) begin
            if (r_data_active && !r_write) begin
              rd_valid <= 1'b1;
              rd_data  <= HRDATA;
            end
            if (r_addr_active) begin
              // Address accepted: its data phase starts now
              r_data_active <= 1'b1;
              HWSTRB        <= f_strb(r_size, HADDR[1:0], r_write);
              if (r_write) HWDATA <= r_wdata[{r_abeat, 5'd0} +: 32];
              if (w_last_abeat) begin
                HTRANS        <= TR_IDLE;
                HMASTLOCK     <= 1'b0;
                r_addr_active <= 1'b0;
              end else begin
                HTRANS  <= TR_SEQ;
                HADDR   <= HADDR + (32'd1 << r_size[1:0]);
                r_abeat <= r_abeat + 2'd1;
              end
            end else begin
              r_data_active <= 1'b0;
            end
          end
          if (w_nstate == S_FIN) HWSTRB <= 4'h0;
        end
        S_FIN: begin
          HTRANS        <= TR_IDLE;
          HMASTLOCK     <= 1'b0;
          HWSTRB        <= 4'h0;
          r_addr_active <= 1'b0;
          r_data_active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// tb/tb_ahb_master.sv - directed vector bench for ahb_master
module tb_ahb_master;

  logic         HCLK, HRESETn;
  logic         cmd_valid, cmd_ready, cmd_write, cmd_incr4, cmd_lock;
  logic [31:0]  cmd_addr;
  logic [2:0]   cmd_size;
  logic [127:0] cmd_wdata;
  logic         rd_valid, done, done_err;
  logic [31:0]  rd_data;
  logic [31:0]  HADDR, HWDATA, HRDATA;
  logic         HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]   HSIZE, HBURST;
  logic [3:0]   HPROT, HWSTRB;
  logic [1:0]   HTRANS;

  ahb_master #(.TIMEOUT_CYC(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_incr4(cmd_incr4),
    .cmd_lock(cmd_lock), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HWSTRB(HWSTRB), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        incr4;
    logic        lock;
    logic [31:0] wd0;
    logic        illegal;
    logic [3:0]  strb;
    int          beats;
  } vec_t;

  typedef struct {
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        rdv;
    logic [31:0] rdd;
    logic        dn;
    logic        err;
    logic        wchk;
    logic [31:0] wd;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
  } cyc_t;

  vec_t vecs[13];
  cyc_t sq[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Waits for cmd_ready, presents one command, returns at the first address-phase sample
  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic i4, input logic lk, input logic [127:0] wd);
    int k;
    k = 0;
    while (!cmd_ready && k < 10) begin
      tick();
      k++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_incr4 = i4; cmd_lock = lk; cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("check_htrans", 32'(HTRANS), 32'd0);
    chk("check_ready", 32'(cmd_ready), 32'd0);
    tick();
  endtask

  task automatic run_seq(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_htrans%0d", tag, i), 32'(HTRANS), 32'(sq[i].htrans));
      if (sq[i].htrans != 2'b00) chk($sformatf("%s_haddr%0d", tag, i), HADDR, sq[i].haddr);
      chk($sformatf("%s_rdv%0d", tag, i), 32'(rd_valid), 32'(sq[i].rdv));
      if (sq[i].rdv) chk($sformatf("%s_rdd%0d", tag, i), rd_data, sq[i].rdd);
      chk($sformatf("%s_done%0d", tag, i), 32'(done), 32'(sq[i].dn));
      if (sq[i].dn) chk($sformatf("%s_err%0d", tag, i), 32'(done_err), 32'(sq[i].err));
      if (sq[i].wchk) chk($sformatf("%s_hwdata%0d", tag, i), HWDATA, sq[i].wd);
      HREADY = sq[i].rdy; HRESP = sq[i].resp; HRDATA = sq[i].rdata;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic got_done, seen_rdv, seen_done;
    int   nb;

    vecs[0]  = '{32'h0000_0000, 3'd2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'hF, 1};
    vecs[1]  = '{32'h0000_000D, 3'd0, 1'b0, 1'b0, 32'h0000_AB00, 1'b0, 4'h2, 1};
    vecs[2]  = '{32'h0000_000E, 3'd0, 1'b0, 1'b0, 32'h00CD_0000, 1'b0, 4'h4, 1};
    vecs[3]  = '{32'h0000_000F, 3'd0, 1'b0, 1'b0, 32'h1200_0000, 1'b0, 4'h8, 1};
    vecs[4]  = '{32'h0000_0016, 3'd1, 1'b0, 1'b0, 32'hBEEF_0000, 1'b0, 4'hC, 1};
    vecs[5]  = '{32'h0000_0010, 3'd1, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 4'h3, 1};
    vecs[6]  = '{32'h0000_0001, 3'd2, 1'b0, 1'b0, 32'h5555_5555, 1'b1, 4'h0, 0};
    vecs[7]  = '{32'h0000_0003, 3'd1, 1'b0, 1'b0, 32'h6666_6666, 1'b1, 4'h0, 0};
    vecs[8]  = '{32'h0000_0004, 3'd3, 1'b0, 1'b0, 32'h7777_7777, 1'b1, 4'h0, 0};
    vecs[9]  = '{32'h0000_03F8, 3'd2, 1'b1, 1'b0, 32'h8888_8888, 1'b1, 4'h0, 0};
    vecs[10] = '{32'h0000_03F0, 3'd2, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 4'hF, 4};
    vecs[11] = '{32'h0000_03FE, 3'd0, 1'b1, 1'b0, 32'h9999_9999, 1'b1, 4'h0, 0};
    vecs[12] = '{32'h0000_03FC, 3'd0, 1'b1, 1'b0, 32'h0000_00C3, 1'b0, 4'h1, 4};

    HRESETn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0;
    cmd_incr4 = 1'b0; cmd_lock = 1'b0; cmd_wdata = 128'h0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    #2 HRESETn = 1'b0;
    tick(); tick();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd2);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hwstrb", 32'(HWSTRB), 32'd0);
    chk("hprot", 32'(HPROT), 32'h3);
    HRESETn = 1'b1;
    #1;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    tick();
    chk("ready_after_edge", 32'(cmd_ready), 32'd1);

    // Table of write commands with a zero-wait slave
    for (int i = 0; i < 13; i++) begin
      issue(1'b1, vecs[i].addr, vecs[i].size, vecs[i].incr4, vecs[i].lock,
            {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, vecs[i].wd0});
      if (vecs[i].illegal) begin
        chk($sformatf("v%0d_ill_done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d_ill_err", i), 32'(done_err), 32'd1);
        chk($sformatf("v%0d_ill_htrans", i), 32'(HTRANS), 32'd0);
      end else begin
        chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'h2);
        chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].addr);
        chk($sformatf("v%0d_hburst", i), 32'(HBURST), vecs[i].incr4 ? 32'd3 : 32'd0);
        chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'd1);
        chk($sformatf("v%0d_lock", i), 32'(HMASTLOCK), 32'(vecs[i].lock));
        chk($sformatf("v%0d_strb_a", i), 32'(HWSTRB), 32'(vecs[i].strb));
        tick();
        chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].wd0);
        chk($sformatf("v%0d_strb_d", i), 32'(HWSTRB), 32'(vecs[i].strb));
        nb = 1;
        got_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
          if (HTRANS == 2'b11) nb++;
          if (done) begin
            got_done = 1'b1;
            break;
          end
          tick();
        end
        chk($sformatf("v%0d_done", i), 32'(got_done), 32'd1);
        chk($sformatf("v%0d_beats", i), 32'(nb), 32'(vecs[i].beats));
        chk($sformatf("v%0d_err", i), 32'(done_err), 32'd0);
      end
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle_lock", i), 32'(HMASTLOCK), 32'd0);
    end

    // INCR4 read from 0x0, one wait state while address 0x4 is pending
    sq[0] = '{2'b10, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0};
    sq[1] = '{2'b11, 32'h4, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    sq[2] = '{2'b11, 32'h4, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1111_1111};
    sq[3] = '{2'b11, 32'h8, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2222_2222};
    sq[4] = '{2'b11, 32'hC, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333};
    sq[5] = '{2'b00, 32'h0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4444_4444};
    sq[6] = '{2'b00, 32'h0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0};
    issue(1'b0, 32'h0, 3'd2, 1'b1, 1'b0, 128'h0);
    chk("rd_hburst", 32'(HBURST), 32'd3);
    chk("rd_hwstrb", 32'(HWSTRB), 32'd0);
    run_seq("rd4", 7);

    // INCR4 write from 0x8, two-cycle ERROR on the first beat
    sq[0] = '{2'b10, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    sq[1] = '{2'b11, 32'hC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0};
    sq[2] = '{2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
    sq[3] = '{2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    sq[4] = '{2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    issue(1'b1, 32'h8, 3'd2, 1'b1, 1'b0, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    run_seq("werr", 5);

    // Timeout: HREADY stuck low through the first data phase
    issue(1'b0, 32'h40, 3'd2, 1'b1, 1'b0, 128'h0);
    chk("tmo_nonseq", 32'(HTRANS), 32'h2);
    HREADY = 1'b1;
    tick();
    chk("tmo_seq_addr", HADDR, 32'h44);
    HREADY = 1'b0;
    seen_rdv = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (rd_valid) seen_rdv = 1'b1;
      if (k < 16) begin
        chk($sformatf("tmo_busy%0d", k), 32'(HTRANS), 32'h3);
        chk($sformatf("tmo_nodone%0d", k), 32'(done), 32'd0);
      end
    end
    chk("tmo_htrans", 32'(HTRANS), 32'd0);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_err", 32'(done_err), 32'd1);
    chk("tmo_no_rdv", 32'(seen_rdv), 32'd0);
    HREADY = 1'b1;
    tick();
    chk("tmo_done_pulse", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a locked halfword INCR4 read
    issue(1'b0, 32'h80, 3'd1, 1'b1, 1'b1, 128'h0);
    chk("mid_lock_nonseq", 32'(HMASTLOCK), 32'd1);
    HREADY = 1'b1;
    tick();
    chk("mid_lock_seq", 32'(HMASTLOCK), 32'd1);
    chk("mid_seq_addr", HADDR, 32'h82);
    HREADY = 1'b0;
    tick();
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'd0);
    chk("arst_haddr", HADDR, 32'h0);
    chk("arst_hsize", 32'(HSIZE), 32'd2);
    chk("arst_hburst", 32'(HBURST), 32'd0);
    chk("arst_lock", 32'(HMASTLOCK), 32'd0);
    chk("arst_hwdata", HWDATA, 32'h0);
    chk("arst_hwstrb", 32'(HWSTRB), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("arst_rdv", 32'(rd_valid), 32'd0);
    seen_done = done;
    HREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    HRESETn = 1'b1;
    tick();
    if (done) seen_done = 1'b1;
    chk("arst_no_done", 32'(seen_done), 32'd0);
    chk("arst_ready_back", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16, which is the number of consecutive HREADY-low data-phase cycles before the command is aborted.
REQ-002 The block SHALL have these ports, clock and reset first:
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both 1 at an edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  start byte address.
- cmd_size  in  3  HSIZE value; only 0 (byte), 1 (halfword) and 2 (word) are legal.
- cmd_incr4  in  1  1 = INCR4 burst, 0 = SINGLE.
- cmd_lock  in  1  locked command.
- cmd_wdata  in  128  write data; beat i is bits [32i+31:32i]; sampled at accept.
- rd_valid  out  1  one-cycle pulse per completed read beat.
- rd_data  out  32  read data, qualified by rd_valid.
- done  out  1  one-cycle pulse when the command ends.
- done_err  out  1  error flag, qualified by done.
- HADDR  out  32  bus address.
- HWRITE  out  1  bus write flag.
- HSIZE  out  3  bus transfer size.
- HBURST  out  3  bus burst type.
- HPROT  out  4  bus protection, constant 4'b0011.
- HTRANS  out  2  bus transfer type.
- HMASTLOCK  out  1  bus lock.
- HWDATA  out  32  bus write data.
- HWSTRB  out  4  bus byte strobes.
- HRDATA  in  32  bus read data.
- HREADY  in  1  bus ready.
- HRESP  in  1  bus response; 1 = ERROR.

Function
REQ-003 The block SHALL implement states IDLE, CHECK, XFER, DRAIN and FIN; cmd_ready SHALL be 1 only in IDLE.
REQ-004 On accept, the block SHALL register all cmd_* inputs and move to CHECK.
REQ-005 In CHECK, a command SHALL be illegal if any of the following hold:
- cmd_size is greater than 2.
- cmd_size=1 and addr[0]=1.
- cmd_size=2 and addr[1:0] is not 0.
- it is an INCR4 whose last beat crosses a 1 KB boundary.
REQ-006 An illegal command SHALL go to FIN with done_err=1, and HTRANS SHALL stay IDLE throughout (no bus activity).
REQ-007 A legal command SHALL go from CHECK to XFER; the first address phase SHALL drive HTRANS=NONSEQ, HBURST=SINGLE(000) or INCR4(011), and HADDR=cmd_addr.
REQ-008 Address and data phases SHALL be pipelined: the address phase of beat n+1 overlaps the data phase of beat n; each beat after the first SHALL drive HTRANS=SEQ with HADDR incremented by 1<<cmd_size.
REQ-009 While HREADY=0, all address-phase outputs and HWDATA SHALL hold their values; a phase advances only on an edge with HREADY=1.
REQ-010 HWDATA SHALL be driven in the data phase of beat i with beat i of cmd_wdata.
REQ-011 HWSTRB SHALL be decoded from the address phase and held through the data phase:
- byte: 4'b0001 << addr[1:0].
- halfword: 4'b0011 << {addr[1],1'b0}.
- word: 4'hF.
- reads: 4'h0.
REQ-012 When the last address phase is accepted, the block SHALL drive HTRANS=IDLE and enter DRAIN for the final data phase.
REQ-013 A read beat SHALL complete on an edge with HREADY=1 and HRESP=0; rd_valid SHALL pulse in the next cycle with rd_data equal to the sampled HRDATA.
REQ-014 Error on HRESP=1 with HREADY=0 (first error cycle): the next cycle SHALL drive HTRANS=IDLE, cancelling any pending address phase.
REQ-015 Error on HRESP=1 with HREADY=1: the block SHALL end the command with done_err=1, issue no further beats, and produce no rd_valid for that beat.
REQ-016 A timeout counter SHALL count consecutive HREADY=0 cycles in a data phase and clear whenever HREADY=1.
REQ-017 When the timeout counter reaches TIMEOUT_CYC, the block SHALL drive HTRANS=IDLE, go to FIN with done_err=1, and issue no further rd_valid.
REQ-018 FIN SHALL last one cycle and pulse done; the next state SHALL be IDLE.
REQ-019 Minimum latency for a zero-wait SINGLE write SHALL be:
- accept edge, then CHECK cycle.
- address cycle, then data cycle.
- FIN (done) cycle.
REQ-020 HMASTLOCK SHALL equal the registered cmd_lock for every address phase of the command and SHALL be 0 otherwise.
REQ-021 When idle, the block SHALL drive HTRANS=IDLE, HMASTLOCK=0 and HWSTRB=0.

Reset
REQ-022 HRESETn=0 SHALL immediately, without waiting for a clock edge, set:
- state to IDLE and all counters to 0.
- HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=2, HBURST=0, HMASTLOCK=0, HWDATA=0, HWSTRB=0.
- cmd_ready=0, rd_valid=0, rd_data=0, done=0, done_err=0.
REQ-023 cmd_ready SHALL rise on the first edge after HRESETn deasserts.
REQ-024 Reset asserted mid-burst SHALL abandon the command with no done pulse.

Verification
REQ-025 SINGLE word write of 0xDEADBEEF to 0x0, HREADY=1 -> NONSEQ at 0x0 with HWSTRB=F, HWDATA=0xDEADBEEF in the next cycle, done=1 and done_err=0 one cycle later.
REQ-026 Byte writes to 0x0D, 0x0E and 0x0F -> HWSTRB of 2, 4 and 8 respectively; halfword write to 0x16 -> HWSTRB=C.
REQ-027 INCR4 word read from 0x0 with slave HRDATA 11..,22..,33..,44.. and one wait state on beat 2 -> bus activity as follows:
- HADDR 0, 4, 8, C with HTRANS NONSEQ, SEQ, SEQ, SEQ.
- The beat-2 address is held for 2 cycles.
- 4 rd_valid pulses in order, then done with done_err=0.
REQ-028 INCR4 write from 0x8 where the slave gives an ERROR on beat 1 (two-cycle response) -> HTRANS=IDLE after the first error cycle, no address 0x10, done_err=1.
REQ-029 Word write to 0x1, or INCR4 word at 0x3F8 -> no NONSEQ on the bus, done_err=1 two cycles after accept.
REQ-030 HREADY held low for 16 cycles -> HTRANS=IDLE, done_err=1; reset mid-burst -> all outputs at reset values with no clock edge, and no done pulse.
